dlf16_cvt_arbiter: RTL and testbench

- Shares one DLFloat16-to-int32 conversion datapath among NUM_REQ requesters (e.g. per-lane FPU writeback ports).
- Round-robin arbitration, per-requester valid/ready, registered conversion stage, single response port tagged with requester ID.
- Sits between the FPU issue lanes and the integer result bus; one conversion in flight at a time.

---
 rtl/dlf16_cvt_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dlf16_cvt_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlf16_cvt_arbiter.sv
// Round-robin shared DLFloat16 -> int32 converter, one conversion in flight.
// Optional DLF16_CVT_STATUS_EN adds resp_flags = {invalid, saturated, inexact}.
module dlf16_cvt_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [31:0]            resp_data
`ifdef DLF16_CVT_STATUS_EN
  ,
  output logic [2:0]             resp_flags
`endif
);

  typedef enum logic [1:0] {IDLE, CONVERT, RESPOND} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_tag;
  logic [ID_W-1:0] r_rid;
  logic [15:0]     r_op;
  logic [31:0]     r_data;
  logic [2:0]      r_flags;

  logic [NUM_REQ-1:0] w_rot;
  logic               w_found;
  logic [ID_W:0]      w_off;
  logic [ID_W:0]      w_sum;
  logic [ID_W:0]      w_inc;
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_ptr_nxt;
  logic [15:0]        w_op;

  // Rotate so bit 0 is the requester at r_ptr; lowest set bit wins.
  always_comb begin
    w_rot = (req_valid >> r_ptr)
          | (req_valid << ((ID_W+1)'(NUM_REQ) - {1'b0, r_ptr}));
    w_found = 1'b0;
    w_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = (ID_W+1)'(k);
      end
    end
    w_sum = {1'b0, r_ptr} + w_off;
    if (w_sum >= (ID_W+1)'(NUM_REQ))
      w_sum = w_sum - (ID_W+1)'(NUM_REQ);
    w_win = w_sum[ID_W-1:0];
    w_inc = w_sum + 1'b1;
    if (w_inc == (ID_W+1)'(NUM_REQ))
      w_inc = '0;
    w_ptr_nxt = w_inc[ID_W-1:0];
    w_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == ID_W'(i))
        w_op = req_data[16*i +: 16];
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_next    = CONVERT;
          req_ready = NUM_REQ'(1) << w_win;
        end
      end
      CONVERT: w_next = RESPOND;
      RESPOND: begin
        if (resp_ready)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (rst)
      req_ready = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  logic [5:0]  w_exp;
  logic [9:0]  w_sig;
  logic [5:0]  w_rsh;
  logic [31:0] w_mag;
  logic [31:0] w_res;
  logic        w_inv;
  logic        w_sat;
  logic        w_inx;

  // exp 31..39 shifts right (may lose bits), 40..61 shifts left, >=62 saturates.
  always_comb begin
    w_exp = r_op[14:9];
    w_sig = {1'b1, r_op[8:0]};
    w_rsh = 6'd40 - w_exp;
    w_mag = '0;
    w_res = '0;
    w_inv = 1'b0;
    w_sat = 1'b0;
    w_inx = 1'b0;
    if (r_op[14:0] == 15'h7FFF) begin
      w_inv = 1'b1;
    end else if (w_exp < 6'd31) begin
      w_inx = (w_exp != 6'd0);
    end else if (w_exp >= 6'd62) begin
      w_sat = 1'b1;
      w_res = r_op[15] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (w_exp >= 6'd40) begin
      w_mag = {22'd0, w_sig} << (w_exp - 6'd40);
      w_res = r_op[15] ? -w_mag : w_mag;
    end else begin
      w_mag = {22'd0, w_sig >> w_rsh};
      w_inx = |(w_sig & ~(10'h3FF << w_rsh));
      w_res = r_op[15] ? -w_mag : w_mag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_tag   <= '0;
      r_op    <= '0;
      r_rid   <= '0;
      r_data  <= '0;
      r_flags <= '0;
    end else begin
      if (r_state == IDLE && w_found) begin
        r_op  <= w_op;
        r_tag <= w_win;
        r_ptr <= w_ptr_nxt;
      end
      if (r_state == CONVERT) begin
        r_data  <= w_res;
        r_rid   <= r_tag;
        r_flags <= {w_inv, w_sat, w_inx};
      end
    end
  end

  assign resp_valid = (r_state == RESPOND);
  assign resp_id    = r_rid;
  assign resp_data  = r_data;

`ifdef DLF16_CVT_STATUS_EN
  assign resp_flags = r_flags;
`else
  logic w_flags_unused;
  assign w_flags_unused = ^r_flags;
`endif

endmodule

// File: tb/tb_dlf16_cvt_arbiter.sv
// Bench for dlf16_cvt_arbiter: directed scenarios plus random traffic
// against a cycle-level reference model.
module tb_dlf16_cvt_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    rv;
  logic [15:0]     rd [N];
  logic [16*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            resp_valid;
  logic            resp_ready;
  logic [IW-1:0]   resp_id;
  logic [31:0]     resp_data;
`ifdef DLF16_CVT_STATUS_EN
  logic [2:0]      resp_flags;
`endif

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++)
      req_data[16*i +: 16] = rd[i];
  end

  dlf16_cvt_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (rv),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data)
`ifdef DLF16_CVT_STATUS_EN
    ,
    .resp_flags (resp_flags)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference conversion: {invalid, saturated, inexact, value}.
  function automatic logic [34:0] cvt(input logic [15:0] x);
    int          e;
    longint      num;
    longint      mag;
    logic [31:0] r;
    logic        inv;
    logic        sat;
    logic        inx;
    e   = int'(x[14:9]) - 31;
    r   = '0;
    inv = 1'b0;
    sat = 1'b0;
    inx = 1'b0;
    if (x[14:0] == 15'h7FFF) begin
      inv = 1'b1;
    end else if (x[14:9] == 6'd0) begin
      r = '0;
    end else if (e < 0) begin
      inx = 1'b1;
    end else if (e >= 31) begin
      sat = 1'b1;
      r   = x[15] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      num = longint'(512 + int'(x[8:0])) * (longint'(1) << e);
      mag = num / 512;
      inx = (num % 512) != 0;
      r   = x[15] ? 32'(-mag) : 32'(mag);
    end
    return {inv, sat, inx, r};
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  int          m_ptr;
  bit          m_busy;
  int          m_wait;
  int          m_id;
  logic [34:0] m_res;
  int          last_grant;
  logic [N-1:0] obs_rdy;
  logic        obs_valid;
  logic [31:0] obs_data;
  int          lg_id [$];
  logic [31:0] lg_data [$];
  logic [2:0]  lg_flags [$];

  task automatic clear_log();
    lg_id.delete();
    lg_data.delete();
    lg_flags.delete();
  endtask

  // Entered and left at posedge+1; checks outputs, then advances the model.
  task automatic step();
    int           w;
    logic [N-1:0] exp_rdy;
    bit           exp_v;
    w       = m_busy ? -1 : pick(rv, m_ptr);
    exp_rdy = (w >= 0) ? N'(1) << w : '0;
    exp_v   = m_busy && (m_wait == 0);
    #3;
    obs_rdy   = req_ready;
    obs_valid = resp_valid;
    obs_data  = resp_data;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("resp_valid", 64'(resp_valid), 64'(exp_v));
    if (exp_v) begin
      chk("resp_id", 64'(resp_id), 64'(m_id));
      chk("resp_data", 64'(resp_data), 64'(m_res[31:0]));
`ifdef DLF16_CVT_STATUS_EN
      chk("resp_flags", 64'(resp_flags), 64'(m_res[34:32]));
`endif
    end
    if (resp_valid && resp_ready) begin
      lg_id.push_back(int'(resp_id));
      lg_data.push_back(resp_data);
`ifdef DLF16_CVT_STATUS_EN
      lg_flags.push_back(resp_flags);
`else
      lg_flags.push_back(3'b000);
`endif
    end
    last_grant = w;
    @(posedge clk);
    if (m_busy) begin
      if (m_wait > 0) m_wait--;
      else if (resp_ready) m_busy = 1'b0;
    end else if (w >= 0) begin
      m_busy = 1'b1;
      m_wait = 1;
      m_id   = w;
      m_res  = cvt(rd[w]);
      m_ptr  = (w + 1) % N;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rv  = '1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_data", 64'(resp_data), 64'(0));
    chk("rst_resp_id", 64'(resp_id), 64'(0));
`ifdef DLF16_CVT_STATUS_EN
    chk("rst_resp_flags", 64'(resp_flags), 64'(0));
`endif
    rv     = '0;
    m_busy = 1'b0;
    m_ptr  = 0;
    m_wait = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_until_idle();
    int k;
    resp_ready = 1'b1;
    for (k = 0; k < 60; k++) begin
      step();
      if (last_grant >= 0) rv[last_grant] = 1'b0;
      if (!m_busy && rv == '0) break;
    end
    chk("idle_timeout", 64'(k < 60), 64'(1));
  endtask

  function automatic logic [15:0] rnd_op();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 5))
      0: v[14:9] = 6'($urandom_range(31, 61));
      1: v[14:9] = 6'($urandom_range(31, 40));
      2: v[14:0] = 15'h7FFF;
      3: v[14:9] = 6'($urandom_range(55, 63));
      default: ;
    endcase
    return v;
  endfunction

  logic [15:0] t3v [4];
  logic [31:0] t3e [4];
  int          cnt;

  initial begin
    rst        = 1'b1;
    rv         = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < N; i++) rd[i] = '0;
    m_ptr  = 0;
    m_busy = 1'b0;
    m_wait = 0;
    m_id   = 0;
    m_res  = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Single request, latency
    clear_log();
    resp_ready = 1'b1;
    rv[0] = 1'b1;
    rd[0] = 16'hC280;
    step();
    chk("t1_ready", 64'(obs_rdy), 64'(4'b0001));
    rv[0] = 1'b0;
    step();
    chk("t1_convert_not_valid", 64'(obs_valid), 64'(0));
    step();
    chk("t1_valid", 64'(obs_valid), 64'(1));
    chk("t1_log_size", 64'(lg_id.size()), 64'(1));
    if (lg_id.size() > 0) begin
      chk("t1_id", 64'(lg_id[0]), 64'(0));
      chk("t1_data", 64'(lg_data[0]), 64'(32'hFFFF_FFFB));
    end

    // All four requesters, round-robin order
    do_reset();
    clear_log();
    rd[0] = 16'h4280;
    rd[1] = 16'hC4C0;
    rd[2] = 16'h3E00;
    rd[3] = 16'h3C00;
    rv = 4'hF;
    run_until_idle();
    chk("t2_log_size", 64'(lg_id.size()), 64'(4));
    if (lg_id.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t2_order", 64'(lg_id[i]), 64'(i));
      chk("t2_d0", 64'(lg_data[0]), 64'(32'd5));
      chk("t2_d1", 64'(lg_data[1]), 64'(32'hFFFF_FFF5));
      chk("t2_d2", 64'(lg_data[2]), 64'(32'd1));
      chk("t2_d3", 64'(lg_data[3]), 64'(32'd0));
`ifdef DLF16_CVT_STATUS_EN
      chk("t2_inexact", 64'(lg_flags[3]), 64'(3'b001));
`endif
    end
    rv = 4'hF;
    step();
    chk("t2_wrap_grant0", 64'(obs_rdy), 64'(4'b0001));
    rv[0] = 1'b0;
    run_until_idle();

    // Saturation, NaN, negative zero
    clear_log();
    t3v[0] = 16'h7DFF; t3e[0] = 32'h7FFF_FFFF;
    t3v[1] = 16'hFDFF; t3e[1] = 32'h8000_0000;
    t3v[2] = 16'h7FFF; t3e[2] = 32'h0;
    t3v[3] = 16'h8000; t3e[3] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      rv[2] = 1'b1;
      rd[2] = t3v[i];
      run_until_idle();
    end
    chk("t3_log_size", 64'(lg_data.size()), 64'(4));
    if (lg_data.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t3_data", 64'(lg_data[i]), 64'(t3e[i]));
`ifdef DLF16_CVT_STATUS_EN
      chk("t3_f0", 64'(lg_flags[0]), 64'(3'b010));
      chk("t3_f1", 64'(lg_flags[1]), 64'(3'b010));
      chk("t3_f2", 64'(lg_flags[2]), 64'(3'b100));
      chk("t3_f3", 64'(lg_flags[3]), 64'(3'b000));
`endif
    end

    // Back-pressure with a pending requester
    clear_log();
    resp_ready = 1'b0;
    rv[0] = 1'b1;
    rd[0] = 16'h4280;
    step();
    rv[0] = 1'b0;
    rv[1] = 1'b1;
    rd[1] = 16'hC4C0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", 64'(obs_valid), 64'(1));
      chk("t4_hold_data", 64'(obs_data), 64'(32'd5));
      chk("t4_hold_ready", 64'(obs_rdy), 64'(0));
    end
    resp_ready = 1'b1;
    step();
    chk("t4_accept_cycle_ready", 64'(obs_rdy), 64'(0));
    step();
    chk("t4_next_ready", 64'(obs_rdy), 64'(4'b0010));
    rv[1] = 1'b0;
    run_until_idle();

    // Reset mid-conversion, then pointer restart
    rv[0] = 1'b1;
    rd[0] = 16'h3E00;
    step();
    rv[0] = 1'b0;
    do_reset();
    rv[3] = 1'b1;
    rd[3] = 16'h4280;
    step();
    chk("t5_grant3", 64'(obs_rdy), 64'(4'b1000));
    rv[3] = 1'b0;
    run_until_idle();
    rv[2] = 1'b1;
    rd[2] = 16'h4280;
    run_until_idle();
    do_reset();
    rv = 4'b1010;
    rd[1] = 16'h4280;
    rd[3] = 16'hC280;
    step();
    chk("t5_ptr_restart", 64'(obs_rdy), 64'(4'b0010));
    rv[1] = 1'b0;
    run_until_idle();

    // Requester withdraws before grant
    clear_log();
    rv[0] = 1'b1;
    rd[0] = 16'h4280;
    step();
    rv[0] = 1'b0;
    rv[1] = 1'b1;
    rd[1] = 16'h3E00;
    step();
    rv[1] = 1'b0;
    run_until_idle();
    cnt = 0;
    foreach (lg_id[i]) if (lg_id[i] == 1) cnt++;
    chk("t6_no_id1", 64'(cnt), 64'(0));

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i] && $urandom_range(0, 3) == 0) begin
          rv[i] = 1'b1;
          rd[i] = rnd_op();
        end else if (rv[i] && $urandom_range(0, 63) == 0) begin
          rv[i] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step();
        if (last_grant >= 0) rv[last_grant] = 1'b0;
      end
    end
    run_until_idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
